// File: rtl/seq_det_ctrl.sv
// -----------------------------------------------------------------------------
// seq_det_ctrl
//
// Word-level controller for a bit-serial Moore sequence detector. Accepts
// parallel words over a valid/ready handshake and shifts each word MSB-first
// into the detector's x input, one bit per clock. The detector's Moore output
// is sampled one cycle after each bit, detections are counted (saturating),
// and a one-cycle done pulse marks the end of each word. The controller also
// drives the detector's reset, so a synchronous clear wipes the detector, the
// count and the sticky flag without a global reset.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   in_valid     in_data holds a word to process
//   in_ready     controller can accept a word this cycle
//   in_data      word to serialize, MSB first
//   clear        synchronous clear of detector, count and sticky flag
//   det_x        serial bit to the detector x input (registered)
//   det_clr      active-high reset to the detector (registered)
//   det_out      detector Moore output
//   done         one-cycle pulse after a word's last result is sampled
//   match_count  saturating count of sampled detections
//   match_any    sticky: set by the first detection
// -----------------------------------------------------------------------------
module seq_det_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic             det_x,
    output logic             det_clr,
    input  logic             det_out,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             match_any
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;      // remaining bits, next one to present at the MSB
    logic [IDX_W-1:0] idx;        // index of the bit currently on det_x
    logic             sample_en;  // det_out reflects the bit presented last cycle
    logic             accept;

    // in_ready is combinational on clear so that a clear arriving together
    // with in_valid blocks the handshake in that same cycle.
    assign in_ready = (state == IDLE) && !clear;
    assign accept   = in_valid && in_ready;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others (e.g. sample_en vs state).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            sample_en   <= 1'b0;
            det_x       <= 1'b0;
            det_clr     <= 1'b1;   // hold the detector in reset with us
            done        <= 1'b0;
            match_count <= '0;
            match_any   <= 1'b0;
        end else begin
            // Detector reset follows clear by exactly one cycle.
            det_clr <= clear;

            if (clear) begin
                // Abandon any word in flight; no done pulse, no late sample.
                state       <= IDLE;
                sample_en   <= 1'b0;
                det_x       <= 1'b0;
                done        <= 1'b0;
                match_count <= '0;
                match_any   <= 1'b0;
            end else begin
                // A bit is on det_x during every SHIFT cycle; its result is
                // visible on det_out the following cycle.
                sample_en <= (state == SHIFT);
                done      <= 1'b0;

                if (sample_en && det_out) begin
                    match_any <= 1'b1;
                    if (match_count != CNT_MAX) begin
                        match_count <= match_count + 1'b1;
                    end
                end

                case (state)
                    IDLE: begin
                        if (accept) begin
                            // MSB goes out straight away; the rest waits in shreg.
                            det_x <= in_data[WIDTH-1];
                            shreg <= {in_data[WIDTH-2:0], 1'b0};
                            idx   <= '0;
                            state <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (idx == LAST_IDX) begin
                            det_x <= 1'b0;
                            state <= DRAIN;
                        end else begin
                            det_x <= shreg[WIDTH-1];
                            shreg <= {shreg[WIDTH-2:0], 1'b0};
                            idx   <= idx + 1'b1;
                        end
                    end
                    DRAIN: begin
                        // Last bit's result is sampled this cycle.
                        done  <= 1'b1;
                        state <= DONE;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
